// File: rtl/snes_rom_dump_ctrl_if.sv
// Byte stream from the ROM dump sequencer to the host link.
// Each beat carries the captured byte and the ROM address it came from.
interface snes_rom_dump_ctrl_if;
    logic [7:0]  out_data;
    logic [19:0] out_addr;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output out_data,
        output out_addr,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_addr,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/snes_rom_dump_ctrl.sv
// Linear SNES cartridge ROM dumper: addresses the ROM, waits the access time,
// captures each byte onto a valid/ready stream and keeps a 16-bit additive checksum.
module snes_rom_dump_ctrl #(
    parameter int ACCESS_CYCLES = 3,
    parameter int CNT_W         = 21
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [19:0]          start_addr,
    input  logic [CNT_W-1:0]     length,
    input  logic [7:0]           rom_data,
    output logic [19:0]          rom_addr,
    output logic                 rom_cs_n,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          checksum,
    snes_rom_dump_ctrl_if.master stream
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_PRESENT = 2'd2,
        ST_FINISH  = 2'd3
    } state_t;

    localparam logic [3:0]       ACCESS_INIT = 4'(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // SNES checksum: plain byte sum, wrapping at 16 bits
    function automatic logic [15:0] csum_add(input logic [15:0] sum, input logic [7:0] b);
        csum_add = sum + {8'd0, b};
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [19:0]      rom_addr_r;
    logic [3:0]       wait_cnt_r;
    logic [CNT_W-1:0] remaining_r;
    logic [7:0]       out_data_r;
    logic [19:0]      out_addr_r;
    logic [15:0]      checksum_r;
    logic             rom_cs_n_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             done_r;
    logic             rom_cs_n_nxt_s;
    logic             out_valid_nxt_s;
    logic             busy_nxt_s;
    logic             done_nxt_s;
    logic             start_go_s;
    logic             accept_s;
    logic             last_s;

    assign start_go_s = start && !abort;
    assign accept_s   = (state_r == ST_PRESENT) && stream.out_ready && !abort;
    assign last_s     = (remaining_r == CNT_ONE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; abort outranks every other transition
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_go_s) begin
                    if (length != '0) begin
                        state_nxt_s = ST_SETUP;
                    end else begin
                        state_nxt_s = ST_FINISH;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (wait_cnt_r == 4'd1) begin
                    state_nxt_s = ST_PRESENT;
                end else begin
                    state_nxt_s = ST_SETUP;
                end
            end
            ST_PRESENT: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (stream.out_ready) begin
                    if (last_s) begin
                        state_nxt_s = ST_FINISH;
                    end else begin
                        state_nxt_s = ST_SETUP;
                    end
                end else begin
                    state_nxt_s = ST_PRESENT;
                end
            end
            ST_FINISH: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so control outputs are registered yet cycle-exact
    always_comb begin
        rom_cs_n_nxt_s  = 1'b1;
        out_valid_nxt_s = 1'b0;
        busy_nxt_s      = 1'b0;
        done_nxt_s      = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
            end
            ST_SETUP: begin
                rom_cs_n_nxt_s = 1'b0;
                busy_nxt_s     = 1'b1;
            end
            ST_PRESENT: begin
                rom_cs_n_nxt_s  = 1'b0;
                out_valid_nxt_s = 1'b1;
                busy_nxt_s      = 1'b1;
            end
            ST_FINISH: begin
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Control output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_cs_n_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            rom_cs_n_r  <= rom_cs_n_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    // Address, access timer, byte count, capture and checksum datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_addr_r  <= 20'd0;
            wait_cnt_r  <= 4'd0;
            remaining_r <= '0;
            out_data_r  <= 8'd0;
            out_addr_r  <= 20'd0;
            checksum_r  <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_go_s) begin
                        checksum_r <= 16'd0;
                        if (length != '0) begin
                            rom_addr_r  <= start_addr;
                            remaining_r <= length;
                            wait_cnt_r  <= ACCESS_INIT;
                        end
                    end
                end
                ST_SETUP: begin
                    if (!abort) begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                        if (wait_cnt_r == 4'd1) begin
                            out_data_r <= rom_data;
                            out_addr_r <= rom_addr_r;
                        end
                    end
                end
                ST_PRESENT: begin
                    if (accept_s) begin
                        checksum_r  <= csum_add(checksum_r, out_data_r);
                        remaining_r <= remaining_r - CNT_ONE;
                        if (!last_s) begin
                            rom_addr_r <= rom_addr_r + 20'd1;
                            wait_cnt_r <= ACCESS_INIT;
                        end
                    end
                end
                default: begin
                    wait_cnt_r <= wait_cnt_r;
                end
            endcase
        end
    end

    assign rom_addr         = rom_addr_r;
    assign rom_cs_n         = rom_cs_n_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign checksum         = checksum_r;
    assign stream.out_data  = out_data_r;
    assign stream.out_addr  = out_addr_r;
    assign stream.out_valid = out_valid_r;

endmodule

// File: tb/tb_snes_rom_dump_ctrl.sv
// Directed bench for snes_rom_dump_ctrl; the ROM model returns the low byte of the address.
module tb_snes_rom_dump_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [19:0] start_addr;
    logic [20:0] length;
    logic [7:0]  rom_data;
    logic [19:0] rom_addr;
    logic        rom_cs_n;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    int pass_cnt;
    int total_cnt;

    logic [7:0]  cap_data[$];
    logic [19:0] cap_addr[$];
    int          cap_cyc[$];
    int          done_cnt;
    int          valid_cnt;

    snes_rom_dump_ctrl_if sif ();

    snes_rom_dump_ctrl #(
        .ACCESS_CYCLES(3),
        .CNT_W        (21)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .start_addr(start_addr),
        .length    (length),
        .rom_data  (rom_data),
        .rom_addr  (rom_addr),
        .rom_cs_n  (rom_cs_n),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum),
        .stream    (sif)
    );

    assign rom_data = rom_addr[7:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        cap_data.delete();
        cap_addr.delete();
        cap_cyc.delete();
        done_cnt  = 0;
        valid_cnt = 0;
    endtask

    // Pulse start for one cycle; returns just after the edge that samples it
    task automatic do_start(input logic [19:0] a, input logic [20:0] n);
        start_addr = a;
        length     = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Log handshakes, done pulses and valid cycles for ncyc cycles (index 0 = just after the start edge)
    task automatic watch(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            if (sif.out_valid) valid_cnt++;
            if (done) done_cnt++;
            if (sif.out_valid && sif.out_ready) begin
                cap_data.push_back(sif.out_data);
                cap_addr.push_back(sif.out_addr);
                cap_cyc.push_back(i);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total_cnt++;
        if ({rom_addr, rom_cs_n, sif.out_data, sif.out_addr, sif.out_valid, busy, done, checksum} !==
            {20'd0, 1'b1, 8'd0, 20'd0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            $display("FAIL reset_values: got addr=%h cs_n=%b data=%h oaddr=%h valid=%b busy=%b done=%b csum=%h",
                     rom_addr, rom_cs_n, sif.out_data, sif.out_addr, sif.out_valid, busy, done, checksum);
        end else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        clear_log();
        sif.out_ready = 1'b1;
        do_start(20'h07FC0, 21'd4);
        watch(20);
        total_cnt++;
        if (cap_data.size() !== 4) $display("FAIL basic_count: got %0d want 4", cap_data.size());
        else pass_cnt++;
        for (int k = 0; k < 4 && k < cap_data.size(); k++) begin
            total_cnt++;
            if (cap_data[k] !== 8'(8'hC0 + k) || cap_addr[k] !== 20'(20'h07FC0 + k))
                $display("FAIL basic_byte%0d: got %h@%h want %h@%h", k, cap_data[k], cap_addr[k],
                         8'(8'hC0 + k), 20'(20'h07FC0 + k));
            else pass_cnt++;
        end
        // first valid three edges after the sampling edge, then one byte every four cycles
        total_cnt++;
        if (cap_cyc.size() != 4 || cap_cyc[0] != 3 || cap_cyc[1] != 7 || cap_cyc[2] != 11 || cap_cyc[3] != 15)
            $display("FAIL basic_timing: got cycles %p want 3,7,11,15", cap_cyc);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt !== 1) $display("FAIL basic_done: got %0d pulses want 1", done_cnt);
        else pass_cnt++;
        total_cnt++;
        if (checksum !== 16'h0306 || busy !== 1'b0 || rom_cs_n !== 1'b1)
            $display("FAIL basic_end: got csum=%h busy=%b cs_n=%b want 0306 0 1", checksum, busy, rom_cs_n);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        clear_log();
        sif.out_ready = 1'b1;
        do_start(20'hFFFFE, 21'd3);
        watch(16);
        total_cnt++;
        if (cap_addr.size() != 3 || cap_addr[0] !== 20'hFFFFE || cap_addr[1] !== 20'hFFFFF || cap_addr[2] !== 20'h00000)
            $display("FAIL wrap_addrs: got %p want FFFFE,FFFFF,00000", cap_addr);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt !== 1 || rom_addr !== 20'h00000 || checksum !== 16'h01FD)
            $display("FAIL wrap_end: got done=%0d rom_addr=%h csum=%h want 1 00000 01FD", done_cnt, rom_addr, checksum);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [7:0]  d0;
        logic [19:0] a0;
        logic [19:0] r0;
        logic        stable;
        int          n;
        clear_log();
        sif.out_ready = 1'b0;
        do_start(20'h00140, 21'd2);
        n = 0;
        while (!sif.out_valid && n < 20) begin
            tick();
            n++;
        end
        total_cnt++;
        if (!sif.out_valid || sif.out_data !== 8'h40 || sif.out_addr !== 20'h00140)
            $display("FAIL bp_first: got valid=%b %h@%h want 1 40@00140", sif.out_valid, sif.out_data, sif.out_addr);
        else pass_cnt++;
        d0 = sif.out_data;
        a0 = sif.out_addr;
        r0 = rom_addr;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!sif.out_valid || sif.out_data !== d0 || sif.out_addr !== a0 || rom_addr !== r0 || rom_cs_n !== 1'b0)
                stable = 1'b0;
        end
        total_cnt++;
        if (stable !== 1'b1) $display("FAIL bp_hold: got stable=%b want 1", stable);
        else pass_cnt++;
        sif.out_ready = 1'b1;
        tick();
        n = 1;
        while (!sif.out_valid && n < 20) begin
            tick();
            n++;
        end
        total_cnt++;
        if (n != 4 || sif.out_data !== 8'h41 || sif.out_addr !== 20'h00141)
            $display("FAIL bp_second: got %0d cycles %h@%h want 4 41@00141", n, sif.out_data, sif.out_addr);
        else pass_cnt++;
        watch(4);
        total_cnt++;
        if (done_cnt !== 1 || checksum !== 16'h0081)
            $display("FAIL bp_end: got done=%0d csum=%h want 1 0081", done_cnt, checksum);
        else pass_cnt++;
    endtask

    task automatic test_zero_length();
        clear_log();
        sif.out_ready = 1'b1;
        do_start(20'h12345, 21'd0);
        total_cnt++;
        if (busy !== 1'b1 || done !== 1'b1 || sif.out_valid !== 1'b0 || checksum !== 16'h0000)
            $display("FAIL zero_finish: got busy=%b done=%b valid=%b csum=%h want 1 1 0 0000",
                     busy, done, sif.out_valid, checksum);
        else pass_cnt++;
        tick();
        watch(5);
        total_cnt++;
        if (busy !== 1'b0 || done_cnt !== 0 || valid_cnt !== 0)
            $display("FAIL zero_idle: got busy=%b extra_done=%0d valid_cycles=%0d want 0 0 0", busy, done_cnt, valid_cnt);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        int n;
        clear_log();
        sif.out_ready = 1'b1;
        do_start(20'h002A0, 21'd5);
        watch(7);
        n = 0;
        while (!sif.out_valid && n < 10) begin
            tick();
            n++;
        end
        total_cnt++;
        if (!sif.out_valid || sif.out_addr !== 20'h002A1)
            $display("FAIL abort_byte2: got valid=%b addr=%h want 1 002A1", sif.out_valid, sif.out_addr);
        else pass_cnt++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || sif.out_valid !== 1'b0 || rom_cs_n !== 1'b1 || done !== 1'b0 || checksum !== 16'h00A0)
            $display("FAIL abort_idle: got busy=%b valid=%b cs_n=%b done=%b csum=%h want 0 0 1 0 00A0",
                     busy, sif.out_valid, rom_cs_n, done, checksum);
        else pass_cnt++;
        watch(6);
        total_cnt++;
        if (done_cnt !== 0) $display("FAIL abort_nodone: got %0d pulses want 0", done_cnt);
        else pass_cnt++;
        // abort wins over a simultaneous start in IDLE
        abort = 1'b1;
        do_start(20'h00050, 21'd2);
        abort = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || checksum !== 16'h00A0)
            $display("FAIL abort_start: got busy=%b csum=%h want 0 00A0", busy, checksum);
        else pass_cnt++;
        clear_log();
        do_start(20'h00050, 21'd2);
        watch(12);
        total_cnt++;
        if (done_cnt !== 1 || checksum !== 16'h00A1 || cap_data.size() != 2)
            $display("FAIL abort_restart: got done=%0d csum=%h bytes=%0d want 1 00A1 2", done_cnt, checksum, cap_data.size());
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        clear_log();
        sif.out_ready = 1'b1;
        do_start(20'h01234, 21'd3);
        tick();
        total_cnt++;
        if (busy !== 1'b1 || rom_cs_n !== 1'b0 || rom_addr !== 20'h01234)
            $display("FAIL areset_setup: got busy=%b cs_n=%b addr=%h want 1 0 01234", busy, rom_cs_n, rom_addr);
        else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({rom_addr, rom_cs_n, sif.out_data, sif.out_addr, sif.out_valid, busy, done, checksum} !==
            {20'd0, 1'b1, 8'd0, 20'd0, 1'b0, 1'b0, 1'b0, 16'd0})
            $display("FAIL areset_values: got addr=%h cs_n=%b busy=%b csum=%h", rom_addr, rom_cs_n, busy, checksum);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        tick();
        clear_log();
        do_start(20'h01234, 21'd2);
        watch(12);
        total_cnt++;
        if (cap_data.size() != 2 || cap_data[0] !== 8'h34 || cap_addr[0] !== 20'h01234 ||
            cap_data[1] !== 8'h35 || cap_addr[1] !== 20'h01235 || done_cnt !== 1 || checksum !== 16'h0069)
            $display("FAIL areset_redump: got bytes=%p addrs=%p done=%0d csum=%h", cap_data, cap_addr, done_cnt, checksum);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        reset         = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        start_addr    = 20'd0;
        length        = 21'd0;
        sif.out_ready = 1'b1;
        clear_log();
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_length();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
